// File: rtl/fetch_ctrl_pkg.sv
// Shared types and encodings for the fetch-stage PC sequencer.
// State, branch-select and width constants live here.
package fetch_ctrl_pkg;

    localparam int PC_W  = 8;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [1:0] SEL_SEQ = 2'd0;
    localparam logic [1:0] SEL_BRA = 2'd1;
    localparam logic [1:0] SEL_RAA = 2'd2;
    localparam logic [1:0] SEL_JMP = 2'd3;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory handshake plus execute-stage redirect bundle.
// master = fetch_ctrl, slave = memory / execute side.
interface fetch_ctrl_if;
    import fetch_ctrl_pkg::*;

    logic            imem_req;
    logic            imem_ack;
    logic            br_valid;
    logic [1:0]      BS;
    logic            PS;
    logic            Z;
    logic [PC_W-1:0] BrA;
    logic [PC_W-1:0] RAA;

    modport master (
        output imem_req,
        input  imem_ack,
        input  br_valid,
        input  BS,
        input  PS,
        input  Z,
        input  BrA,
        input  RAA
    );

    modport slave (
        input  imem_req,
        output imem_ack,
        output br_valid,
        output BS,
        output PS,
        output Z,
        output BrA,
        output RAA
    );

endinterface

// File: rtl/fetch_ctrl_branch_resolve.sv
// Combinational BS/PS/Z branch resolution: select, raw taken and target.
// Kept standalone so the branch predictor can reuse it.
module branch_resolve
    import fetch_ctrl_pkg::*;
(
    input  logic [1:0]      BS,
    input  logic            PS,
    input  logic            Z,
    input  logic [PC_W-1:0] BrA,
    input  logic [PC_W-1:0] RAA,
    input  logic            br_valid,
    output logic [1:0]      sel,
    output logic            taken_raw,
    output logic [PC_W-1:0] target
);

    assign sel[1]    = BS[1];
    assign sel[0]    = ((PS ^ Z) | BS[1]) & BS[0];
    assign taken_raw = br_valid & (sel != SEL_SEQ);

    always_comb begin
        target = BrA;
        unique case (sel)
            SEL_SEQ: target = BrA;
            SEL_BRA: target = BrA;
            SEL_RAA: target = RAA;
            SEL_JMP: target = BrA;
            default: target = BrA;
        endcase
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage PC sequencer: imem handshake, redirects and
// fixed-length wrong-path flush after each taken redirect.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned     FLUSH_CYCLES = 2,
    parameter logic [PC_W-1:0] RESET_PC     = 8'h00
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            stall,
    fetch_ctrl_if.master    bus,
    output logic [PC_W-1:0] PC,
    output logic [PC_W-1:0] PC_1,
    output logic            instr_valid,
    output logic            flush,
    output logic            taken
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       sel;
    logic             taken_raw;
    logic [PC_W-1:0]  target;
    logic             fetching;

    branch_resolve u_br (
        .BS        (bus.BS),
        .PS        (bus.PS),
        .Z         (bus.Z),
        .BrA       (bus.BrA),
        .RAA       (bus.RAA),
        .br_valid  (bus.br_valid),
        .sel       (sel),
        .taken_raw (taken_raw),
        .target    (target)
    );

    assign fetching     = (state == FETCH);
    assign taken        = fetching & taken_raw & (sel != SEL_SEQ);
    assign bus.imem_req = fetching & ~stall & ~taken;
    assign instr_valid  = bus.imem_req & bus.imem_ack;
    assign PC_1         = PC + 8'd1;

    // Redirect outranks stall and ack; an ack in that cycle is dropped.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            PC    <= RESET_PC;
            flush <= 1'b0;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state <= FETCH;
                end
                FETCH: begin
                    if (taken) begin
                        PC    <= target;
                        state <= FLUSH;
                        flush <= 1'b1;
                        cnt   <= CNT_W'(FLUSH_CYCLES - 1);
                    end else if (instr_valid) begin
                        PC <= PC_1;
                    end
                end
                FLUSH: begin
                    if (cnt == '0) begin
                        state <= FETCH;
                        flush <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    flush <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: reset, sequential fetch, wrap,
// branches, stall/ack wait and asynchronous reset mid-flush.
module tb_fetch_ctrl;

    logic       CLK;
    logic       reset;
    logic       stall;
    logic [7:0] PC;
    logic [7:0] PC_1;
    logic       instr_valid;
    logic       flush;
    logic       taken;

    int checks = 0;
    int errors = 0;

    fetch_ctrl_if bus ();

    fetch_ctrl #(
        .FLUSH_CYCLES (2),
        .RESET_PC     (8'h00)
    ) dut (
        .CLK         (CLK),
        .reset       (reset),
        .stall       (stall),
        .bus         (bus),
        .PC          (PC),
        .PC_1        (PC_1),
        .instr_valid (instr_valid),
        .flush       (flush),
        .taken       (taken)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic st(input string tag, input logic [7:0] pc,
                      input logic req, input logic iv,
                      input logic fl, input logic tk);
        chk({tag, ".PC"}, PC, pc);
        chk({tag, ".req"}, {7'd0, bus.imem_req}, {7'd0, req});
        chk({tag, ".ivalid"}, {7'd0, instr_valid}, {7'd0, iv});
        chk({tag, ".flush"}, {7'd0, flush}, {7'd0, fl});
        chk({tag, ".taken"}, {7'd0, taken}, {7'd0, tk});
    endtask

    task automatic cyc();
        @(negedge CLK);
        #1;
    endtask

    task automatic br(input logic v, input logic [1:0] bs,
                      input logic ps, input logic z,
                      input logic [7:0] bra, input logic [7:0] raa);
        bus.br_valid = v;
        bus.BS       = bs;
        bus.PS       = ps;
        bus.Z        = z;
        bus.BrA      = bra;
        bus.RAA      = raa;
    endtask

    initial begin
        reset        = 1'b0;
        stall        = 1'b0;
        bus.imem_ack = 1'b0;
        br(1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        st("rst", 8'h00, 0, 0, 0, 0);

        // free-run from reset
        repeat (3) @(negedge CLK);
        reset        = 1'b1;
        bus.imem_ack = 1'b1;
        #1;
        st("idle", 8'h00, 0, 0, 0, 0);
        cyc(); st("f0", 8'h00, 1, 1, 0, 0);
        cyc(); st("f1", 8'h01, 1, 1, 0, 0);
        chk("f1.PC_1", PC_1, 8'h02);
        cyc(); st("f2", 8'h02, 1, 1, 0, 0);
        cyc(); cyc();
        cyc(); st("f5", 8'h05, 1, 1, 0, 0);

        // conditional branch taken: PS=0, Z=1
        br(1'b1, 2'b01, 1'b0, 1'b1, 8'h40, 8'h11);
        #1;
        st("cb", 8'h05, 0, 0, 0, 1);
        cyc(); st("cb.fl1", 8'h40, 0, 0, 1, 0);
        br(1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00);
        cyc(); st("cb.fl2", 8'h40, 0, 0, 1, 0);
        cyc(); st("cb.res", 8'h40, 1, 1, 0, 0);

        // conditional branch not taken: Z=0
        cyc();
        br(1'b1, 2'b01, 1'b0, 1'b0, 8'h70, 8'h11);
        #1;
        st("nb", 8'h41, 1, 1, 0, 0);
        cyc(); st("nb.nxt", 8'h42, 1, 1, 0, 0);

        // indirect jump while stalled with ack high
        stall = 1'b1;
        br(1'b1, 2'b10, 1'b1, 1'b0, 8'h55, 8'h9A);
        #1;
        st("ij", 8'h42, 0, 0, 0, 1);
        cyc(); st("ij.fl1", 8'h9A, 0, 0, 1, 0);
        stall = 1'b0;
        br(1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00);
        bus.imem_ack = 1'b0;
        cyc(); st("ij.fl2", 8'h9A, 0, 0, 1, 0);
        cyc(); st("ij.res", 8'h9A, 1, 0, 0, 0);

        // stall 4 cycles then ack wait 3 cycles
        stall        = 1'b1;
        bus.imem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            st("stl", 8'h9A, 0, 0, 0, 0);
            cyc();
        end
        stall        = 1'b0;
        bus.imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            st("wait", 8'h9A, 1, 0, 0, 0);
            cyc();
        end
        bus.imem_ack = 1'b1;
        #1;
        st("ack", 8'h9A, 1, 1, 0, 0);
        cyc(); st("ack.nxt", 8'h9B, 1, 1, 0, 0);

        // wrap via unconditional jump to FE
        br(1'b1, 2'b11, 1'b0, 1'b0, 8'hFE, 8'h33);
        #1;
        st("jw", 8'h9B, 0, 0, 0, 1);
        cyc(); st("jw.fl1", 8'hFE, 0, 0, 1, 0);
        br(1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00);
        cyc(); st("jw.fl2", 8'hFE, 0, 0, 1, 0);
        cyc(); st("wFE", 8'hFE, 1, 1, 0, 0);
        chk("wFE.PC_1", PC_1, 8'hFF);
        cyc(); st("wFF", 8'hFF, 1, 1, 0, 0);
        chk("wFF.PC_1", PC_1, 8'h00);
        cyc(); st("w00", 8'h00, 1, 1, 0, 0);

        // async reset in the second flush cycle; br_valid held to
        // confirm it is ignored while flushing
        br(1'b1, 2'b11, 1'b0, 1'b0, 8'h20, 8'h00);
        #1;
        st("ar", 8'h00, 0, 0, 0, 1);
        cyc(); st("ar.fl1", 8'h20, 0, 0, 1, 0);
        stall = 1'b1;
        cyc(); st("ar.fl2", 8'h20, 0, 0, 1, 0);
        reset = 1'b0;
        #1;
        st("ar.rst", 8'h00, 0, 0, 0, 0);
        stall = 1'b0;
        br(1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00);
        cyc(); st("ar.hold", 8'h00, 0, 0, 0, 0);
        reset = 1'b1;
        #1;
        st("ar.idle", 8'h00, 0, 0, 0, 0);
        cyc(); st("ar.f0", 8'h00, 1, 1, 0, 0);
        cyc(); st("ar.f1", 8'h01, 1, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
